// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: interrupt-entry sequencer states, interrupt
// kinds, processor status flag bit positions (shared with the status
// register) and the helper that forms the status byte pushed on entry.
package cpu6502_pkg;

  typedef enum logic [2:0] {IDLE, T1, PCH, PCL, PUSHP, VL, VH} state_t;
  typedef enum logic [1:0] {K_NMI, K_IRQ, K_BRK} kind_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;  // unused bit, always pushed as 1
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  // Status byte as it appears on the stack: bit 5 forced high, B marks BRK.
  function automatic logic [7:0] push_status(input logic [7:0] p, input logic brk);
    logic [7:0] r;
    r         = p;
    r[FLAG_U] = 1'b1;
    r[FLAG_B] = brk;
    return r;
  endfunction

endpackage

// File: rtl/interrupt_push_sequencer_if.sv
// Memory bus used by the interrupt push sequencer.
//   o_address/o_data/o_rw : driven by the bus master (the sequencer)
//   i_data/i_rdy          : read data and ready, driven by the memory side
interface interrupt_push_sequencer_if;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic        o_rw;
  logic [7:0]  i_data;
  logic        i_rdy;

  modport master (output o_address, o_data, o_rw, input i_data, i_rdy);
  modport slave  (input o_address, o_data, o_rw, output i_data, i_rdy);
endinterface

// File: rtl/interrupt_push_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with pending latch.
//   clk, rst : clock, synchronous active-high reset
//   nmi_n    : raw NMI line, active low
//   service  : one-cycle pulse from the sequence that takes the NMI
//   pending  : NMI edge seen and not yet serviced
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic service,
  output logic pending
);

  logic nmi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q   <= 1'b1;
      pending <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      // A fresh edge wins over a same-cycle service so it is never lost.
      if (nmi_q && !nmi_n)
        pending <= 1'b1;
      else if (service)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_push_sequencer.sv
// 6502 BRK/IRQ/NMI entry sequencer: dummy read, push PCH, push PCL, push P,
// fetch vector low, fetch vector high, then a one-cycle PC load pulse.
// Owns the bus only while o_busy is high.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_sync, i_brk           : opcode-fetch boundary, BRK decoded
//   i_irq_n, i_nmi_n        : level IRQ, falling-edge NMI (both active low)
//   i_p, i_pc, i_sp         : status, return PC, stack pointer
//   bus                     : address/data/rw out, data/rdy in
//   o_busy                  : sequence in progress
//   o_sp_dec, o_set_i       : pulses to stack pointer / status register
//   o_pc_load, o_vector     : load fetched handler address into PC
// Optional: define NMI_HIJACK_EN to let an NMI arriving up to the P push of
// an IRQ/BRK sequence take over its vector fetch.
module interrupt_push_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_sync,
  input  logic                       i_brk,
  input  logic                       i_irq_n,
  input  logic                       i_nmi_n,
  input  logic [7:0]                 i_p,
  input  logic [15:0]                i_pc,
  input  logic [7:0]                 i_sp,
  interrupt_push_sequencer_if.master bus,
  output logic                       o_busy,
  output logic                       o_sp_dec,
  output logic                       o_set_i,
  output logic                       o_pc_load,
  output logic [15:0]                o_vector
);

  state_t      state, state_next;
  kind_t       kind, start_kind;
  logic [15:0] pc_q;
  logic        use_nmi_vec;
  logic        nmi_pending, nmi_service;
  logic        irq_req, start, stall, hijack;
  logic [15:0] vec_base;

  assign irq_req = !i_irq_n && !i_p[FLAG_I];
  assign start   = (state == IDLE) && i_sync && (nmi_pending || irq_req || i_brk);
  assign stall   = !bus.i_rdy && (state inside {T1, VL, VH});

  always_comb begin
    start_kind = K_BRK;
    if (nmi_pending)  start_kind = K_NMI;
    else if (irq_req) start_kind = K_IRQ;
  end

`ifdef NMI_HIJACK_EN
  assign hijack = nmi_pending && !use_nmi_vec && (state inside {T1, PCH, PCL, PUSHP});
`else
  assign hijack = 1'b0;
`endif

  assign nmi_service = (start && start_kind == K_NMI) || hijack;

  nmi_edge_detect u_nmi (
    .clk     (i_clk),
    .rst     (i_reset),
    .nmi_n   (i_nmi_n),
    .service (nmi_service),
    .pending (nmi_pending)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!stall) begin
      unique case (state)
        IDLE:    if (start) state_next = T1;
        T1:      state_next = PCH;
        PCH:     state_next = PCL;
        PCL:     state_next = PUSHP;
        PUSHP:   state_next = VL;
        VL:      state_next = VH;
        VH:      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      kind        <= K_IRQ;
      pc_q        <= '0;
      use_nmi_vec <= 1'b0;
      o_vector    <= '0;
      o_pc_load   <= 1'b0;
    end else begin
      o_pc_load <= (state == VH) && bus.i_rdy;
      if (start) begin
        kind        <= start_kind;
        pc_q        <= i_pc;
        use_nmi_vec <= (start_kind == K_NMI);
      end else if (hijack) begin
        use_nmi_vec <= 1'b1;
      end
      if (state == VL && bus.i_rdy) o_vector[7:0]  <= bus.i_data;
      if (state == VH && bus.i_rdy) o_vector[15:8] <= bus.i_data;
    end
  end

  assign vec_base = use_nmi_vec ? VEC_NMI : VEC_IRQ;

  always_comb begin
    o_busy        = (state != IDLE);
    bus.o_rw      = 1'b1;
    bus.o_address = '0;
    bus.o_data    = '0;
    o_sp_dec      = 1'b0;
    o_set_i       = 1'b0;
    unique case (state)
      T1:  bus.o_address = pc_q + 16'(kind == K_BRK);
      PCH: begin
        bus.o_rw      = 1'b0;
        bus.o_address = {STACK_PAGE, i_sp};
        bus.o_data    = pc_q[15:8];
        o_sp_dec      = 1'b1;
      end
      PCL: begin
        bus.o_rw      = 1'b0;
        bus.o_address = {STACK_PAGE, i_sp};
        bus.o_data    = pc_q[7:0];
        o_sp_dec      = 1'b1;
      end
      PUSHP: begin
        bus.o_rw      = 1'b0;
        bus.o_address = {STACK_PAGE, i_sp};
        bus.o_data    = push_status(i_p, kind == K_BRK);
        o_sp_dec      = 1'b1;
        o_set_i       = 1'b1;
      end
      VL:      bus.o_address = vec_base;
      VH:      bus.o_address = vec_base | 16'h0001;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_push_sequencer.sv
module tb_interrupt_push_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_sync, i_brk, i_irq_n, i_nmi_n;
  logic [7:0]  i_p, i_sp;
  logic [15:0] i_pc;
  logic        o_busy, o_sp_dec, o_set_i, o_pc_load;
  logic [15:0] o_vector;
  logic [7:0]  mem [0:65535];

  interrupt_push_sequencer_if bus();

  interrupt_push_sequencer #(
    .STACK_PAGE (8'h01),
    .VEC_NMI    (16'hFFFA),
    .VEC_IRQ    (16'hFFFE)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_sync    (i_sync),
    .i_brk     (i_brk),
    .i_irq_n   (i_irq_n),
    .i_nmi_n   (i_nmi_n),
    .i_p       (i_p),
    .i_pc      (i_pc),
    .i_sp      (i_sp),
    .bus       (bus),
    .o_busy    (o_busy),
    .o_sp_dec  (o_sp_dec),
    .o_set_i   (o_set_i),
    .o_pc_load (o_pc_load),
    .o_vector  (o_vector)
  );

  always #5 clk = ~clk;
  assign bus.i_data = mem[bus.o_address];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected bus cycle; vsel 1/2 = vector low/high fetch, address resolved
  // when checked so a late switch to the NMI vector is honoured.
  typedef struct packed {
    logic        busy, rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        dec, seti, load, stall;
    logic [1:0]  vsel;
  } rec_t;

  function automatic rec_t mk(logic busy, logic rw, logic [15:0] addr, logic [7:0] data,
                              logic dec, logic seti, logic load, logic stall, logic [1:0] vsel);
    rec_t r;
    r.busy = busy; r.rw = rw; r.addr = addr; r.data = data;
    r.dec = dec; r.seti = seti; r.load = load; r.stall = stall; r.vsel = vsel;
    return r;
  endfunction

  rec_t        exp_q[$];
  logic [23:0] wr_log[$];
  int          cyc = 0, set_i_cnt = 0, busy_cnt = 0, pc_load_cyc = -1, start_cyc = 0;
  logic [15:0] last_vector = '0;
  logic        sp_dec_seen = 1'b0;
  logic        pend = 1'b0, nmi_prev = 1'b1, seq_nmi_vec = 1'b0;

  always @(negedge clk) begin
    rec_t        r;
    logic [15:0] ea, base;
    logic [28:0] act, expv;
    logic        idle_now, clr, irq;
    logic [7:0]  pushed;
    int          k, qsize;
    cyc++;
    act = {o_busy, bus.o_rw, bus.o_address, bus.o_data, o_sp_dec, o_set_i, o_pc_load};
    sp_dec_seen = o_sp_dec;
    if (o_busy && !bus.o_rw) wr_log.push_back({bus.o_address, bus.o_data});
    if (o_set_i) set_i_cnt++;
    if (o_busy) busy_cnt++;
    if (o_pc_load) begin pc_load_cyc = cyc; last_vector = o_vector; end

    qsize = exp_q.size();
    r = (qsize == 0) ? mk(0, 1, 16'h0, 8'h0, 0, 0, 0, 0, 0) : exp_q[0];
    idle_now = (qsize == 0) || r.load;
    base = seq_nmi_vec ? 16'hFFFA : 16'hFFFE;
    ea = (r.vsel == 2'd0) ? r.addr : (base | 16'(r.vsel == 2'd2));
    expv = {r.busy, r.rw, ea, r.data, r.dec, r.seti, r.load};
    check("cycle", 32'(act), 32'(expv));
    if (r.load) check("vector", 32'(o_vector), 32'({mem[base | 16'h1], mem[base]}));
    if (qsize != 0 && !(r.stall && !bus.i_rdy)) void'(exp_q.pop_front());

    clr = 1'b0;
    if (i_reset) begin
      exp_q.delete();
      pend = 1'b0;
      nmi_prev = 1'b1;
      seq_nmi_vec = 1'b0;
    end else begin
`ifdef NMI_HIJACK_EN
      if (qsize >= 4 && pend && !seq_nmi_vec) begin seq_nmi_vec = 1'b1; clr = 1'b1; end
`endif
      irq = !i_irq_n && !i_p[2];
      if (idle_now && i_sync && (pend || irq || i_brk)) begin
        k = pend ? 0 : (irq ? 1 : 2);
        if (k == 0) clr = 1'b1;
        seq_nmi_vec = (k == 0);
        pushed = i_p | 8'h20;
        pushed[4] = (k == 2);
        exp_q.push_back(mk(1, 1, i_pc + 16'(k == 2), 8'h00, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(1, 0, {8'h01, i_sp}, i_pc[15:8], 1, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 0, {8'h01, i_sp - 8'd1}, i_pc[7:0], 1, 0, 0, 0, 0));
        exp_q.push_back(mk(1, 0, {8'h01, i_sp - 8'd2}, pushed, 1, 1, 0, 0, 0));
        exp_q.push_back(mk(1, 1, 16'h0, 8'h00, 0, 0, 0, 1, 1));
        exp_q.push_back(mk(1, 1, 16'h0, 8'h00, 0, 0, 0, 1, 2));
        exp_q.push_back(mk(0, 1, 16'h0, 8'h00, 0, 0, 1, 0, 0));
        start_cyc = cyc;
      end
      if (nmi_prev && !i_nmi_n) pend = 1'b1;
      else if (clr)             pend = 1'b0;
      nmi_prev = i_nmi_n;
    end
  end

  // One clock; inputs change 1 time unit after the edge. The stack pointer
  // follows the sequencer's decrement pulses like the real SP register.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (sp_dec_seen) i_sp = i_sp - 8'd1;
  endtask

  task automatic start_seq(input logic irq_n, input logic brk, input logic [7:0] p, input logic [15:0] pc);
    i_irq_n = irq_n; i_brk = brk; i_p = p; i_pc = pc; i_sp = 8'hFD; i_sync = 1'b1;
    cycle();
    i_sync = 1'b0; i_irq_n = 1'b1; i_brk = 1'b0;
  endtask

  int wb, sb, bb;

  initial begin
    for (int unsigned i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
    mem[16'hFFFA] = 8'h78; mem[16'hFFFB] = 8'h56;
    i_reset = 1'b1; i_sync = 1'b0; i_brk = 1'b0; i_irq_n = 1'b1; i_nmi_n = 1'b1;
    i_p = 8'h00; i_pc = 16'h0000; i_sp = 8'hFD; bus.i_rdy = 1'b1;
    repeat (3) cycle();
    i_reset = 1'b0;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_rw", 32'(bus.o_rw), 32'h1);
    check("rst_addr", 32'(bus.o_address), 32'h0);
    check("rst_vector", 32'(o_vector), 32'h0);
    cycle();

    // IRQ service
    wb = wr_log.size(); sb = set_i_cnt;
    start_seq(1'b0, 1'b0, 8'h00, 16'h1234);
    repeat (8) cycle();
    check("irq_nwr", 32'(wr_log.size() - wb), 32'd3);
    check("irq_w0", 32'(wr_log[wb]), 32'h01FD12);
    check("irq_w1", 32'(wr_log[wb+1]), 32'h01FC34);
    check("irq_w2", 32'(wr_log[wb+2]), 32'h01FB20);
    check("irq_vec", 32'(last_vector), 32'h1234);
    check("irq_load_cyc", 32'(pc_load_cyc - start_cyc), 32'd7);
    check("irq_set_i", 32'(set_i_cnt - sb), 32'd1);

    // BRK
    wb = wr_log.size();
    start_seq(1'b1, 1'b1, 8'hC3, 16'h2000);
    repeat (8) cycle();
    check("brk_p", 32'(wr_log[wb+2]), 32'h01FBF3);
    check("brk_vec", 32'(last_vector), 32'h1234);

    // Masked IRQ
    wb = wr_log.size(); bb = busy_cnt;
    start_seq(1'b0, 1'b0, 8'h04, 16'h3000);
    repeat (8) cycle();
    check("mask_nwr", 32'(wr_log.size() - wb), 32'd0);
    check("mask_busy", 32'(busy_cnt - bb), 32'd0);

    // NMI single-cycle pulse while idle
    i_p = 8'h00;
    i_nmi_n = 1'b0; cycle(); i_nmi_n = 1'b1; cycle();
    wb = wr_log.size();
    start_seq(1'b1, 1'b0, 8'h00, 16'h4000);
    repeat (8) cycle();
    check("nmi_p", 32'(wr_log[wb+2]), 32'h01FB20);
    check("nmi_vec", 32'(last_vector), 32'h5678);
    wb = wr_log.size();
    start_seq(1'b1, 1'b0, 8'h00, 16'h4000);
    repeat (8) cycle();
    check("nmi_cleared", 32'(wr_log.size() - wb), 32'd0);

    // Held-low NMI services once only
    wb = wr_log.size();
    i_nmi_n = 1'b0; cycle();
    start_seq(1'b1, 1'b0, 8'h00, 16'h4100);
    repeat (8) cycle();
    start_seq(1'b1, 1'b0, 8'h00, 16'h4200);
    repeat (8) cycle();
    i_nmi_n = 1'b1; cycle();
    check("nmi_hold_nwr", 32'(wr_log.size() - wb), 32'd3);

    // RDY low for 2 cycles from PCH (ignored), 3 cycles in VL (stretches)
    start_seq(1'b0, 1'b0, 8'h00, 16'h5000);   // now in T1
    cycle();                                   // PCH
    bus.i_rdy = 1'b0; cycle(); cycle();        // PCL, PUSHP
    bus.i_rdy = 1'b1; cycle();                 // VL
    bus.i_rdy = 1'b0; repeat (3) cycle();
    bus.i_rdy = 1'b1; repeat (6) cycle();
    check("rdy_load_cyc", 32'(pc_load_cyc - start_cyc), 32'd10);
    check("rdy_vec", 32'(last_vector), 32'h1234);

    // Reset during PCL
    wb = wr_log.size();
    start_seq(1'b0, 1'b0, 8'h00, 16'h6000);   // T1
    cycle(); cycle();                          // PCL
    i_reset = 1'b1; cycle(); i_reset = 1'b0;
    check("rstmid_busy", 32'(o_busy), 32'h0);
    check("rstmid_rw", 32'(bus.o_rw), 32'h1);
    check("rstmid_dec", 32'(o_sp_dec), 32'h0);
    repeat (6) cycle();
    check("rstmid_nwr", 32'(wr_log.size() - wb), 32'd2);
    check("rstmid_vec", 32'(o_vector), 32'h0);

    // NMI edge during PCL of an IRQ sequence
    wb = wr_log.size();
    start_seq(1'b0, 1'b0, 8'h00, 16'h4321);   // T1
    cycle(); cycle();                          // PCL
    i_nmi_n = 1'b0; cycle(); i_nmi_n = 1'b1;
    repeat (6) cycle();
    check("late_nmi_p", 32'(wr_log[wb+2]), 32'h01FB20);
`ifdef NMI_HIJACK_EN
    check("hijack_vec", 32'(last_vector), 32'h5678);
`else
    check("late_nmi_vec", 32'(last_vector), 32'h1234);
    start_seq(1'b1, 1'b0, 8'h00, 16'h4400);
    repeat (8) cycle();
    check("late_nmi_next_vec", 32'(last_vector), 32'h5678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_push_sequencer.md
Name: interrupt_push_sequencer

Overview:
- Writer side of the processor status path: the status register captures P from DB (PLP/RTI); this block drives P onto the data bus.
- Sequences the 7-cycle 6502 BRK/IRQ/NMI entry: dummy read, push PCH, push PCL, push P, fetch vector low, fetch vector high.
- Sits in cpu6502 beside the status register and stack pointer.
- Owns the address/data bus only while o_busy is high.

Parameters:
- STACK_PAGE, 8'h01, high byte of the stack address.
- VEC_NMI, 16'hFFFA, NMI vector base.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector base.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_sync  in  1  instruction boundary (opcode fetch cycle).
- i_brk  in  1  BRK opcode decoded this boundary.
- i_irq_n  in  1  level-sensitive IRQ, active low.
- i_nmi_n  in  1  edge-sensitive NMI, falling edge.
- i_rdy  in  1  bus ready; low stalls read cycles only.
- i_p  in  8  current processor status.
- i_pc  in  16  return PC.
- i_sp  in  8  current stack pointer.
- i_data  in  8  read data bus.
- o_busy  out  1  sequence in progress.
- o_address  out  16  bus address.
- o_data  out  8  write data.
- o_rw  out  1  1=read, 0=write.
- o_sp_dec  out  1  one-cycle pulse: decrement SP.
- o_set_i  out  1  one-cycle pulse: set I flag.
- o_pc_load  out  1  one-cycle pulse: load o_vector into PC.
- o_vector  out  16  fetched handler address.

Behaviour:
- Reset values: state IDLE; o_busy=0, o_rw=1, o_address=0, o_data=0, all pulses 0, o_vector=0; NMI pending cleared; NMI edge history set to 1.
- Reset mid-sequence aborts immediately; no further writes are issued.
- NMI detect:
  - Register i_nmi_n each cycle; a 1->0 transition sets nmi_pending.
  - nmi_pending clears when the sequence that services it latches VEC_NMI.
- Start condition: IDLE and i_sync, with priority nmi_pending > (i_irq_n==0 and i_p[2]==0) > i_brk.
  - Latch the kind (NMI/IRQ/BRK) and i_pc.
  - o_busy rises on the next cycle.
- States, one cycle each:
  - T1: read at the latched PC. For BRK the PC used is PC+1, the signature byte.
  - PCH: write {STACK_PAGE,i_sp} with PC[15:8]; o_sp_dec=1.
  - PCL: same as PCH with PC[7:0].
  - PUSHP: write i_p with bit5=1 and bit4=1 for BRK, 0 for IRQ/NMI; o_sp_dec=1; o_set_i=1.
  - VL: read vector base; capture i_data into o_vector[7:0].
  - VH: read base+1; capture o_vector[15:8]; o_pc_load=1 in the following cycle.
  - After VH, return to IDLE.
- i_p is sampled in PUSHP, so any flag change that lands the same cycle is not pushed.
- RDY: when i_rdy=0 during T1, VL or VH, hold state and outputs. Write states ignore i_rdy.
- Vector base: VEC_NMI for NMI kind, else VEC_IRQ; the low bit is OR'd for the +1 fetch.
- An interrupt arriving while o_busy=1 stays pending; IRQ then re-evaluates against the new I=1 and is masked.

Optional Feature:
- NMI_HIJACK_EN defined: if nmi_pending becomes set during an IRQ/BRK sequence at or before PUSHP:
  - the pushed B bit stays as for the original kind;
  - the vector switches to VEC_NMI;
  - nmi_pending clears.
- Undefined: the vector is fixed at start; the NMI is serviced by the next sequence.

Decomposition:
- Shared package cpu6502_pkg holds:
  - state enum {IDLE,T1,PCH,PCL,PUSHP,VL,VH};
  - kind enum {K_NMI,K_IRQ,K_BRK};
  - flag bit indices C=0,Z=1,I=2,D=3,B=4,V=6,N=7, shared with the status register.
- Sub-module nmi_edge_detect handles the registered falling-edge detect plus pending latch, cleared by a service pulse.

Test Plan:
- IRQ service: i_irq_n=0, i_p=8'h00, i_pc=16'h1234, i_sp=8'hFD, i_sync; vector memory FFFE=34, FFFF=12.
  - Writes in order: 01FD<-12, 01FC<-34, 01FB<-20.
  - o_vector=16'h1234, o_pc_load pulses on cycle 7, o_set_i pulses once.
- BRK: i_brk=1, i_p=8'hC3.
  - Pushed P=8'hF3 (B=1, bit5=1).
  - Vector read from FFFE/FFFF.
- IRQ masked: i_irq_n=0, i_p=8'h04, i_sync.
  - o_busy stays 0 and no writes occur.
- NMI edge: pulse i_nmi_n low for 1 cycle while IDLE, then i_sync.
  - Vector fetched from FFFA/FFFB; pushed P bit4=0; nmi_pending cleared.
  - A held-low i_nmi_n does not retrigger.
- RDY stall: drop i_rdy for 3 cycles in VL and for 2 cycles in PCH.
  - VL is extended by 3 cycles.
  - PCH proceeds without delay.
- Reset mid-sequence and hijack:
  - i_reset asserted in PCL: next cycle o_busy=0, o_rw=1, o_sp_dec=0.
  - With NMI_HIJACK_EN: NMI edge during PCL of an IRQ -> vector FFFA, pushed B=0.
